mult_seq_ctrl: RTL and testbench

//   Control unit for the 8-bit signed shift-add multiplier. Sequences the X/A/B

---
 rtl/mult_seq_ctrl.sv | 103 ++++++++++
 tb/tb_mult_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Control FSM for the signed shift-add multiplier: clears/loads the X/A/B
// datapath, then runs WIDTH add/shift iterations (subtract on the last one).
module mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clr_XA,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the case leaves a signal unassigned (which infers a latch).
        state_d = state_q;
        count_d = count_q;
        Clr_Ld  = 1'b0;
        Clr_XA  = 1'b0;
        Add     = 1'b0;
        Sub     = 1'b0;
        Shift   = 1'b0;
        Busy    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Run wins over a simultaneous load request; a held reset
                // keeps the level-sensitive load strobe quiet.
                if (Run) begin
                    state_d = S_CLR;
                end else begin
                    Clr_Ld = ClearA_LoadB & Reset_n;
                end
            end
            S_CLR: begin
                Clr_XA  = 1'b1;
                Busy    = 1'b1;
                count_d = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                Busy    = 1'b1;
                Add     = M & (count_q != LAST);
                Sub     = M & (count_q == LAST);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
                // The counter is parked at zero on the last iteration so it
                // never holds a value beyond WIDTH-1 while waiting in HOLD.
                if (count_q == LAST) begin
                    count_d = '0;
                    state_d = S_HOLD;
                end else begin
                    count_d = count_q + 1'b1;
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                if (!Run) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!Reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl (WIDTH=8). Inputs change
// 2 time units after the rising edge; outputs are sampled 1 unit later.
module tb_mult_seq_ctrl;

    logic Clk = 1'b0;
    logic Reset_n;
    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Clr_Ld, Clr_XA, Add, Sub, Shift, Busy;

    int total = 0;
    int bad   = 0;

    // Output vector order: {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy}
    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_CLRLD = 6'b100000;
    localparam logic [5:0] O_CLRXA = 6'b010001;
    localparam logic [5:0] O_BUSY  = 6'b000001;
    localparam logic [5:0] O_SHIFT = 6'b000011;

    mult_seq_ctrl #(.WIDTH(8)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_Ld       (Clr_Ld),
        .Clr_XA       (Clr_XA),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    function automatic logic [5:0] outs();
        return {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        total++;
        assert (got == exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and land at the sampling point (edge + 3).
    task automatic step();
        @(posedge Clk);
        #3;
    endtask

    // Starts in IDLE at the sampling point; ends in HOLD at the sampling point.
    // bm holds the multiplier bits presented on M, iteration 0 first.
    task automatic do_mult(input string tag, input logic [7:0] bm,
                           input bit drop_run, input bit noise_load);
        int n_add = 0, n_sub = 0, n_shift = 0, n_busy = 0;
        logic [5:0] exp;
        Run = 1'b1;
        M   = 1'b0;
        @(posedge Clk);
        #2;
        if (drop_run)   Run = 1'b0;
        if (noise_load) ClearA_LoadB = 1'b1;
        #1;
        check({tag, " clr"}, outs(), O_CLRXA);
        n_busy += int'(Busy);
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk);
            #2;
            M = bm[i];
            #1;
            exp = {2'b00, bm[i] & (i != 7), bm[i] & (i == 7), 2'b01};
            check($sformatf("%s add%0d", tag, i), outs(), exp);
            n_add  += int'(Add);
            n_sub  += int'(Sub);
            n_busy += int'(Busy);
            step();
            check($sformatf("%s shift%0d", tag, i), outs(), O_SHIFT);
            n_shift += int'(Shift);
            n_busy  += int'(Busy);
        end
        step();
        check({tag, " hold"}, outs(), O_NONE);
        ClearA_LoadB = 1'b0;
        check_int({tag, " n_add"},   n_add,   $countones(bm[6:0]));
        check_int({tag, " n_sub"},   n_sub,   int'(bm[7]));
        check_int({tag, " n_shift"}, n_shift, 8);
        check_int({tag, " n_busy"},  n_busy,  17);
    endtask

    task automatic go_idle(input string tag);
        Run = 1'b0;
        step();
        check({tag, " idle"}, outs(), O_NONE);
    endtask

    initial begin
        // 1. Reset with every input high, then release.
        Reset_n = 1'b0; Run = 1'b1; ClearA_LoadB = 1'b1; M = 1'b1;
        step();
        check("rst cyc0", outs(), O_NONE);
        step();
        check("rst cyc1", outs(), O_NONE);
        #2;
        Reset_n = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
        step();
        check("post-rst a", outs(), O_NONE);
        step();
        check("post-rst b", outs(), O_NONE);

        // 2. Load request held three cycles in IDLE.
        ClearA_LoadB = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("load cyc%0d", i), outs(), O_CLRLD);
        end
        ClearA_LoadB = 1'b0;
        step();
        check("load released", outs(), O_NONE);

        // 3. B=0x05 with Run released mid-multiply and load noise ignored.
        do_mult("b05", 8'h05, 1'b1, 1'b1);
        go_idle("b05");

        // 4. B=0x80 and B=0xFF.
        do_mult("b80", 8'h80, 1'b0, 1'b0);
        go_idle("b80");
        do_mult("bff", 8'hFF, 1'b0, 1'b0);
        go_idle("bff");

        // 5. Run held 40 cycles: one multiply, then HOLD for the rest.
        do_mult("held", 8'h5A, 1'b0, 1'b0);
        begin
            int busy_hold = 0;
            for (int i = 0; i < 40 - 18; i++) begin
                step();
                busy_hold += int'(outs() != O_NONE);
            end
            check_int("held hold-quiet", busy_hold, 0);
        end
        Run = 1'b0;
        step();
        check("held release", outs(), O_NONE);
        do_mult("second", 8'h33, 1'b0, 1'b0);
        go_idle("second");

        // 6. Reset during SHIFT of iteration 3, then Run+load together in IDLE.
        Run = 1'b1; M = 1'b1;
        step();
        check("abort clr", outs(), O_CLRXA);
        for (int i = 0; i < 8; i++) step();
        check("abort shift3", outs(), O_SHIFT);
        #2;
        Reset_n = 1'b0; ClearA_LoadB = 1'b1;
        step();
        check("abort reset", outs(), O_NONE);
        #2;
        Reset_n = 1'b1;
        #1;
        check("both idle", outs(), O_NONE);
        step();
        check("both clr", outs(), O_CLRXA);
        step();
        check("both add0", outs(), 6'b001001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
